// File: rtl/costas_loop_filter_if.sv
// Costas loop filter bus: phase-error input side plus NCO/lock output side.
// Signals: error_tdata/error_tvalid/is_bpsk/freeze toward the filter;
//          freq_tdata/freq_tvalid/locked/int_sat back from the filter.
interface costas_loop_filter_if #(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 32
);
  logic signed [WIDTH-1:0]     error_tdata;
  logic                        error_tvalid;
  logic                        is_bpsk;
  logic                        freeze;
  logic signed [ACC_WIDTH-1:0] freq_tdata;
  logic                        freq_tvalid;
  logic                        locked;
  logic                        int_sat;

  // Upstream side: drives error samples and mode/freeze controls.
  modport master (
    output error_tdata, error_tvalid, is_bpsk, freeze,
    input  freq_tdata, freq_tvalid, locked, int_sat
  );

  // Filter side.
  modport slave (
    input  error_tdata, error_tvalid, is_bpsk, freeze,
    output freq_tdata, freq_tvalid, locked, int_sat
  );
endinterface

// File: rtl/costas_loop_filter.sv
// PI loop filter for the Costas loop with ACQUIRE/LOCKED lock detector.
// Latency: a valid error sample reaches freq_tdata 2 clocks later; lock flag 1 clock later.
// Backpressure: none; one sample accepted every cycle, freq_tvalid held high after reset.
// Ports: clk, rst (sync, active-high); lf (slave modport) carries error/mode/freeze in and
//        freq_tdata/freq_tvalid/locked/int_sat out.
module costas_loop_filter #(
  parameter int WIDTH        = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int KP_SHIFT     = 4,
  parameter int KI_SHIFT     = 0,
  parameter int INT_LIMIT    = 16777216,
  parameter int CENTER_INC   = 429496730,
  parameter int LOCK_THRESH  = 256,
  parameter int LOCK_COUNT   = 1024,
  parameter int UNLOCK_COUNT = 64
) (
  input logic                clk,
  input logic                rst,
  costas_loop_filter_if.slave lf
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic signed [ACC_WIDTH:0]   INT_MAX_X  = (ACC_WIDTH+1)'(INT_LIMIT);
  localparam logic signed [ACC_WIDTH:0]   INT_MIN_X  = -INT_MAX_X;
  localparam logic signed [ACC_WIDTH-1:0] INT_MAX_A  = ACC_WIDTH'(INT_LIMIT);
  localparam logic signed [ACC_WIDTH-1:0] INT_MIN_A  = -INT_MAX_A;
  localparam logic signed [ACC_WIDTH+1:0] CENTER_X   = (ACC_WIDTH+2)'(CENTER_INC);
  localparam logic signed [ACC_WIDTH+1:0] FREQ_MAX_X = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH+1:0] FREQ_MIN_X = {3'b111, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]              THRESH_W   = (WIDTH+1)'(LOCK_THRESH);
  localparam logic [CNT_W-1:0]            LOCK_CNT_W   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0]            UNLOCK_CNT_W = CNT_W'(UNLOCK_COUNT);

  typedef enum logic {ST_ACQUIRE, ST_LOCKED} lock_state_e;

  // State
  logic signed [ACC_WIDTH-1:0] p_q, p_d;
  logic signed [ACC_WIDTH-1:0] integ_q, integ_d;
  logic signed [ACC_WIDTH-1:0] freq_q, freq_d;
  logic                        int_sat_q, int_sat_d;
  logic                        s1_vld_q;
  logic                        tvalid_q;
  logic                        mode_q;
  lock_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // Input conditioning
  logic signed [ACC_WIDTH-1:0] e_ext, e_kp, e_ki;
  logic signed [ACC_WIDTH:0]   integ_sum, integ_clamp;
  logic signed [WIDTH:0]       e_w;
  logic [WIDTH:0]              e_abs;
  logic                        in_lock;
  logic                        mode_chg;
  logic                        vld;
  logic [CNT_W-1:0]            cnt_inc;
  logic signed [ACC_WIDTH+1:0] sum_x;

  assign vld      = lf.error_tvalid;
  assign mode_chg = (lf.is_bpsk != mode_q);

  assign e_ext = {{(ACC_WIDTH-WIDTH){lf.error_tdata[WIDTH-1]}}, lf.error_tdata};
  assign e_kp  = e_ext <<< KP_SHIFT;
  assign e_ki  = e_ext <<< KI_SHIFT;

  // One extra bit so the integrator update cannot wrap before clamping.
  assign integ_sum = {integ_q[ACC_WIDTH-1], integ_q} + {e_ki[ACC_WIDTH-1], e_ki};

  always_comb begin
    integ_clamp = integ_sum;
    if (integ_sum > INT_MAX_X)      integ_clamp = INT_MAX_X;
    else if (integ_sum < INT_MIN_X) integ_clamp = INT_MIN_X;
  end

  // |e| at WIDTH+1 bits so the most negative sample has a representable magnitude.
  assign e_w     = {lf.error_tdata[WIDTH-1], lf.error_tdata};
  assign e_abs   = e_w[WIDTH] ? unsigned'(-e_w) : unsigned'(e_w);
  assign in_lock = (e_abs <= THRESH_W);

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Stage 1: proportional register, integrator, saturation flag.
  always_comb begin
    p_d       = p_q;
    integ_d   = integ_q;
    int_sat_d = int_sat_q;
    if (vld) p_d = e_kp;
    if (mode_chg) begin
      // Retune from scratch: old frequency estimate is meaningless in the new mode.
      integ_d   = '0;
      int_sat_d = 1'b0;
    end else if (vld) begin
      if (!lf.freeze) integ_d = integ_clamp[ACC_WIDTH-1:0];
      int_sat_d = (integ_d == INT_MAX_A) || (integ_d == INT_MIN_A);
    end
  end

  // Stage 2: centre + P + I, saturated to the output word.
  assign sum_x = CENTER_X
               + {{2{p_q[ACC_WIDTH-1]}}, p_q}
               + {{2{integ_q[ACC_WIDTH-1]}}, integ_q};

  always_comb begin
    freq_d = freq_q;
    if (s1_vld_q) begin
      if (sum_x > FREQ_MAX_X)      freq_d = FREQ_MAX_X[ACC_WIDTH-1:0];
      else if (sum_x < FREQ_MIN_X) freq_d = FREQ_MIN_X[ACC_WIDTH-1:0];
      else                         freq_d = sum_x[ACC_WIDTH-1:0];
    end
  end

  // Lock detector next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mode_chg) begin
      state_d = ST_ACQUIRE;
      cnt_d   = '0;
    end else if (vld) begin
      case (state_q)
        ST_ACQUIRE: begin
          if (!in_lock) begin
            cnt_d = '0;
          end else if (cnt_inc >= LOCK_CNT_W) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_LOCKED: begin
          if (in_lock) begin
            cnt_d = '0;
          end else if (cnt_inc >= UNLOCK_CNT_W) begin
            state_d = ST_ACQUIRE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= '0;
      integ_q   <= '0;
      freq_q    <= ACC_WIDTH'(CENTER_INC);
      int_sat_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      tvalid_q  <= 1'b1;
      mode_q    <= 1'b1;
      state_q   <= ST_ACQUIRE;
      cnt_q     <= '0;
    end else begin
      p_q       <= p_d;
      integ_q   <= integ_d;
      freq_q    <= freq_d;
      int_sat_q <= int_sat_d;
      s1_vld_q  <= vld;
      tvalid_q  <= 1'b1;
      mode_q    <= lf.is_bpsk;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign lf.freq_tdata  = freq_q;
  assign lf.freq_tvalid = tvalid_q;
  assign lf.locked      = (state_q == ST_LOCKED);
  assign lf.int_sat     = int_sat_q;

endmodule

// File: tb/tb_costas_loop_filter.sv
// Directed bench for costas_loop_filter: stimulus pushes expected freq words into a
// queue; an independent monitor pops one per output produced 2 clocks after a valid.
// Lock flag and int_sat are checked directly after the relevant sample.
module tb_costas_loop_filter;
  localparam longint CENTER = 429496730;
  localparam longint LIMIT  = 16777216;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  costas_loop_filter_if #(.WIDTH(16), .ACC_WIDTH(32)) lf ();

  costas_loop_filter dut (
    .clk (clk),
    .rst (rst),
    .lf  (lf)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  int     n_out    = 0;
  longint exp_q[$];
  logic   vld_d1 = 1'b0;
  logic   vld_d2 = 1'b0;
  longint m_integ = 0;
  bit     m_mode  = 1'b1;

  function automatic void check(input string name, input longint got, input longint exp_v);
    n_checks++;
    if (got != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    end
  endfunction

  // Bench-side knowledge of when an output word is due (two edges after a valid).
  always @(posedge clk) begin
    if (rst) begin
      vld_d1 <= 1'b0;
      vld_d2 <= 1'b0;
    end else begin
      vld_d1 <= lf.error_tvalid;
      vld_d2 <= vld_d1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (vld_d2) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL freq_unexpected[%0d]: got %0d expected none", n_out, $signed(lf.freq_tdata));
      end else begin
        check($sformatf("freq[%0d]", n_out), longint'($signed(lf.freq_tdata)), exp_q.pop_front());
      end
    end
  end

  // Drive one valid sample for one cycle; returns at the negedge after it was captured.
  task automatic drive(input int e, input bit frz, input bit bpsk, input bit use_exp, input longint exp_v);
    longint model;
    if (bpsk != m_mode) begin
      m_integ = 0;
      m_mode  = bpsk;
    end else if (!frz) begin
      m_integ = m_integ + e;
      if (m_integ > LIMIT)  m_integ = LIMIT;
      if (m_integ < -LIMIT) m_integ = -LIMIT;
    end
    model = CENTER + 16 * longint'(e) + m_integ;
    exp_q.push_back(use_exp ? exp_v : model);
    lf.error_tdata  = 16'(e);
    lf.error_tvalid = 1'b1;
    lf.freeze       = frz;
    lf.is_bpsk      = bpsk;
    @(negedge clk);
    lf.error_tvalid = 1'b0;
    lf.freeze       = 1'b0;
  endtask

  task automatic send(input int e);
    drive(e, 1'b0, m_mode, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    lf.error_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    lf.error_tvalid = 1'b0;
    lf.error_tdata  = '0;
    lf.is_bpsk      = 1'b1;
    lf.freeze       = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst     = 1'b0;
    m_integ = 0;
    m_mode  = 1'b1;
    @(negedge clk);
    check("rst_freq",   longint'($signed(lf.freq_tdata)), CENTER);
    check("rst_tvalid", longint'(lf.freq_tvalid), 1);
    check("rst_locked", longint'(lf.locked), 0);
    check("rst_int_sat", longint'(lf.int_sat), 0);
  endtask

  initial begin
    do_reset();

    // Idle: NCO parked at centre, no lock.
    for (int i = 0; i < 10; i++) begin
      check("idle_freq",   longint'($signed(lf.freq_tdata)), CENTER);
      check("idle_tvalid", longint'(lf.freq_tvalid), 1);
      check("idle_locked", longint'(lf.locked), 0);
      idle(1);
    end

    // Basic P+I and 2-clock latency.
    drive(100, 1'b0, 1'b1, 1'b1, 429498430);
    drive(0,   1'b0, 1'b1, 1'b1, 429496830);
    idle(3);

    // Integrator saturation.
    do_reset();
    for (int i = 0; i < 512; i++) send(32767);
    check("int_sat_512", longint'(lf.int_sat), 0);
    drive(32767, 1'b0, 1'b1, 1'b1, 446798218);
    check("int_sat_513", longint'(lf.int_sat), 1);
    repeat (3) send(32767);
    idle(2);
    check("int_sat_sticky", longint'(lf.int_sat), 1);
    send(-32767);
    check("int_sat_clear", longint'(lf.int_sat), 0);
    drive(1000, 1'b1, 1'b1, 1'b0, 0);      // frozen integrator, P still live
    send(-500);
    send(-32768);                           // most negative sample
    idle(3);

    // Reset with a sample in flight.
    send(1000);
    do_reset();
    idle(3);
    check("post_rst_freq", longint'($signed(lf.freq_tdata)), CENTER);

    // Lock acquisition with a near miss.
    for (int i = 0; i < 1023; i++) begin
      send((i % 2) ? -200 : 200);
      if (i % 3 == 2) idle(1);
    end
    check("lock_1023", longint'(lf.locked), 0);
    send(300);
    check("lock_reset_300", longint'(lf.locked), 0);
    for (int i = 0; i < 1023; i++) begin
      send((i % 2) ? -200 : 200);
      if (i % 3 == 2) idle(1);
    end
    check("lock_2nd_1023", longint'(lf.locked), 0);
    send(-200);
    check("lock_1024", longint'(lf.locked), 1);

    // Unlock hysteresis.
    repeat (63) send(1000);
    check("unlock_63", longint'(lf.locked), 1);
    send(0);
    check("unlock_gap", longint'(lf.locked), 1);
    repeat (63) send(1000);
    check("unlock_2nd_63", longint'(lf.locked), 1);
    send(1000);
    check("unlock_64", longint'(lf.locked), 0);
    idle(3);

    // Mode change while locked with integrator = 5000.
    do_reset();
    repeat (25)  send(200);
    repeat (998) send(0);
    drive(0, 1'b0, 1'b1, 1'b1, 429501730);
    check("mode_pre_locked", longint'(lf.locked), 1);
    drive(50, 1'b0, 1'b0, 1'b1, 429497530);
    check("mode_chg_locked", longint'(lf.locked), 0);
    drive(0, 1'b0, 1'b0, 1'b1, 429496730);
    idle(4);

    check("queue_drained", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
